// File: rtl/i2d_muldiv_pkg.sv
// Shared definitions for the i2d iterative multiply/divide unit: opcodes,
// datapath widths and result selection.
package i2d_muldiv_pkg;

  localparam int DATA_W = 32;
  localparam int ACC_W  = 2 * DATA_W + 1;

  localparam logic [1:0] I2D_MD_MUL   = 2'b00;
  localparam logic [1:0] I2D_MD_MULHU = 2'b01;
  localparam logic [1:0] I2D_MD_DIVU  = 2'b10;
  localparam logic [1:0] I2D_MD_REMU  = 2'b11;

  function automatic logic is_div(input logic [1:0] op);
    return (op == I2D_MD_DIVU) || (op == I2D_MD_REMU);
  endfunction

  // The accumulator holds {P} for multiply and {R,Q} for divide, so the
  // answer is always either its low or its upper 32 bits.
  function automatic logic [DATA_W-1:0] md_select(input logic [1:0] op,
                                                  input logic [ACC_W-1:0] acc);
    logic [DATA_W-1:0] sel;
    case (op)
      I2D_MD_MUL:   sel = acc[DATA_W-1:0];
      I2D_MD_MULHU: sel = acc[2*DATA_W-1:DATA_W];
      I2D_MD_DIVU:  sel = acc[DATA_W-1:0];
      I2D_MD_REMU:  sel = acc[2*DATA_W-1:DATA_W];
      default:      sel = acc[DATA_W-1:0];
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/i2d_muldiv.sv
// Iterative 32-bit unsigned multiply / restoring divide, one bit per cycle,
// with a single shared 33-bit adder/subtractor and start/busy/done handshake.
module i2d_muldiv
  import i2d_muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        op,
  input  logic              start,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e            state, state_next;
  logic [4:0]        count;
  logic [ACC_W-1:0]  acc, acc_next;
  logic [DATA_W-1:0] a_q, b_q;
  logic [1:0]        op_q;
  logic              accept, div_zero, last_iter;
  logic              sub;
  logic [DATA_W:0]   add_x, add_y;
  logic [DATA_W+1:0] sum;

  assign accept    = start && !flush && (state != RUN);
  assign div_zero  = is_div(op) && (b == '0);
  assign last_iter = (state == RUN) && (count == 5'd31);

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_next = div_zero ? DONE : RUN;
        RUN:     if (count == 5'd31) state_next = DONE;
        DONE:    if (start) state_next = div_zero ? DONE : RUN;
                 else state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Shared adder: multiply adds A to the product's upper half; divide
  // subtracts B from the shifted remainder, carry-out meaning no borrow.
  always_comb begin
    sub   = is_div(op_q);
    add_x = sub ? acc[2*DATA_W-1:DATA_W-1] : acc[ACC_W-1:DATA_W];
    add_y = sub ? ~{1'b0, b_q} : {1'b0, a_q};
    sum   = {1'b0, add_x} + {1'b0, add_y} + {{(DATA_W+1){1'b0}}, sub};
    if (sub) begin
      acc_next = {sum[DATA_W+1] ? sum[DATA_W:0] : acc[2*DATA_W-1:DATA_W-1],
                  acc[DATA_W-2:0], sum[DATA_W+1]};
    end else begin
      acc_next = {1'b0, acc[0] ? sum[DATA_W:0] : acc[ACC_W-1:DATA_W],
                  acc[DATA_W-1:1]};
    end
  end

  // Operand latch and iteration register: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op;
      acc  <= is_div(op) ? {{(DATA_W+1){1'b0}}, a} : {{(DATA_W+1){1'b0}}, b};
    end else if (state == RUN) begin
      acc <= acc_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      result <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        count <= '0;
      end else if (state == RUN) begin
        count <= count + 5'd1;
      end
      if (accept && div_zero) begin
        result <= (op == I2D_MD_REMU) ? a : '1;
      end else if (last_iter && !flush) begin
        result <= md_select(op_q, acc_next);
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_i2d_muldiv.sv
// Scoreboard bench for i2d_muldiv: stimulus pushes expected results computed
// with plain arithmetic; a forked monitor pops and compares on every done.
module tb_i2d_muldiv;
  import i2d_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [1:0]  op = '0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2d_muldiv dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .start(start),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  function automatic logic [31:0] model(input logic [1:0] o,
                                        input logic [31:0] x, y);
    logic [63:0] p;
    p = {32'b0, x} * {32'b0, y};
    case (o)
      I2D_MD_MUL:   return p[31:0];
      I2D_MD_MULHU: return p[63:32];
      I2D_MD_DIVU:  return (y == 0) ? 32'hFFFF_FFFF : x / y;
      default:      return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, y, input bit acc);
    exp_t e;
    op = o; a = x; b = y; start = 1'b1;
    if (acc) begin
      e.res = model(o, x, y);
      e.cyc = cyc + ((o[1] && y == 0) ? 1 : 33);
      sb.push_back(e);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check32(nm, 32'(done), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 60) begin
      tick();
      n++;
    end
    check32("idle_reached", 32'(busy | done), 32'd0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0 result=%h", result);
        end else begin
          e = sb.pop_front();
          check32("done_result", result, e.res);
          check32("done_cycle", 32'(cyc), 32'(e.cyc));
          last_res = e.res;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic [31:0] prior;
    fork
      monitor();
    join_none

    repeat (3) tick();
    check32("reset_busy", 32'(busy), 32'd0);
    check32("reset_done", 32'(done), 32'd0);
    check32("reset_result", result, 32'd0);
    rst = 1'b0;
    tick();

    // MUL 7x6 with exact busy window
    issue(I2D_MD_MUL, 32'd7, 32'd6, 1);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      tick();
    end
    check32("mul_busy_window", 32'(bad), 32'd0);
    check32("mul_done_at_n33", 32'(done), 32'd1);
    check32("mul_busy_low_done", 32'(busy), 32'd0);
    check32("mul_7x6", result, 32'd42);

    wait_idle(); issue(I2D_MD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); wait_done("mul_max_done");
    check32("mul_max", result, 32'h0000_0001);
    wait_idle(); issue(I2D_MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); wait_done("mulhu_max_done");
    check32("mulhu_max", result, 32'hFFFF_FFFE);

    // divide with operands changed mid-run
    wait_idle(); issue(I2D_MD_DIVU, 32'd100, 32'd7, 1);
    repeat (5) tick();
    a = $urandom; b = $urandom;
    wait_done("divu_done");
    check32("divu_100_7", result, 32'd14);
    wait_idle(); issue(I2D_MD_REMU, 32'd100, 32'd7, 1);
    repeat (7) tick();
    a = $urandom; b = $urandom;
    wait_done("remu_done");
    check32("remu_100_7", result, 32'd2);

    // divide by zero
    wait_idle(); issue(I2D_MD_DIVU, 32'h1234, 32'd0, 1);
    check32("divz_done_n1", 32'(done), 32'd1);
    check32("divz_busy", 32'(busy), 32'd0);
    check32("divz_divu", result, 32'hFFFF_FFFF);
    tick();
    check32("divz_busy_after", 32'(busy), 32'd0);
    wait_idle(); issue(I2D_MD_REMU, 32'h1234, 32'd0, 1);
    check32("divz_remu", result, 32'h0000_1234);

    // back-to-back with an ignored start during RUN
    wait_idle(); issue(I2D_MD_MUL, 32'd3, 32'd5, 1);
    wait_done("b2b_first_done");
    check32("b2b_first", result, 32'd15);
    issue(I2D_MD_DIVU, 32'd1000, 32'd33, 1);
    check32("b2b_busy_immediate", 32'(busy), 32'd1);
    repeat (5) tick();
    issue(I2D_MD_MUL, 32'd9, 32'd9, 0);
    wait_done("b2b_second_done");
    repeat (40) tick();

    // flush mid-run
    wait_idle();
    prior = last_res;
    issue(I2D_MD_MUL, 32'd1234, 32'd5678, 1);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check32("flush_busy_low", 32'(busy), 32'd0);
    void'(sb.pop_back());
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) bad++;
      tick();
    end
    check32("flush_no_done", 32'(bad), 32'd0);
    check32("flush_result_kept", result, prior);

    // flush together with start
    op = I2D_MD_MUL; a = 32'd2; b = 32'd2; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check32("flush_start_busy", 32'(busy), 32'd0);
    check32("flush_start_done", 32'(done), 32'd0);

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      wait_idle();
      issue(ro, ra, rb, 1);
      wait_done("rand_done");
    end

    // asynchronous reset mid-run
    wait_idle();
    issue(I2D_MD_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 1);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    check32("arst_busy", 32'(busy), 32'd0);
    check32("arst_done", 32'(done), 32'd0);
    check32("arst_result", result, 32'd0);
    sb.delete();
    tick();
    rst = 1'b0;
    tick();
    issue(I2D_MD_DIVU, 32'hFFFF_FFFF, 32'd3, 1);
    wait_done("post_reset_done");

    wait_idle();
    check32("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
